// File: rtl/weight_seq_pkg.sv
// Shared types and defaults for the weight index sequencer.
// FSM state encoding plus default sizing constants.
package weight_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_IDX_WIDTH   = 12;
    localparam int DEF_NUM_INDICES = 42;
    localparam int DEF_NUM_PASSES  = 64;
    localparam int DEF_PASS_WIDTH  = 7;
    localparam int DEF_BUF_LATENCY = 2;

    // Width of a counter that must reach n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying {last, valid}.
// Matches the weight buffer read latency; it has no enable.
module valid_delay_line
    import weight_seq_pkg::*;
#(
    parameter int DEPTH = DEF_BUF_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_last,
    output logic o_valid,
    output logic o_last
);

    logic [1:0] r_shift [DEPTH];

    // Shift every cycle; a synchronous reset drops in-flight strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_shift[i] <= 2'b00;
            end
        end else begin
            r_shift[0] <= {i_last, i_valid};
            for (int i = 1; i < DEPTH; i++) begin
                r_shift[i] <= r_shift[i-1];
            end
        end
    end

    assign o_valid = r_shift[DEPTH-1][0];
    assign o_last  = r_shift[DEPTH-1][1];

endmodule

// File: rtl/weight_index_sequencer.sv
// Sweeps the weight buffer index over a programmed number of passes
// and produces a data_valid strobe aligned with the buffer output.
module weight_index_sequencer
    import weight_seq_pkg::*;
#(
    parameter int IDX_WIDTH   = DEF_IDX_WIDTH,
    parameter int NUM_INDICES = DEF_NUM_INDICES,
    parameter int NUM_PASSES  = DEF_NUM_PASSES,
    parameter int PASS_WIDTH  = DEF_PASS_WIDTH,
    parameter int BUF_LATENCY = DEF_BUF_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    output logic [IDX_WIDTH-1:0]  index,
    output logic                  index_valid,
    output logic                  data_valid,
    output logic                  last_data,
    output logic [PASS_WIDTH-1:0] pass_count,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = cnt_width(BUF_LATENCY);

    localparam logic [IDX_WIDTH-1:0]  IDX_LAST   = IDX_WIDTH'(NUM_INDICES - 1);
    localparam logic [PASS_WIDTH-1:0] PASS_LAST  = PASS_WIDTH'(NUM_PASSES - 1);
    localparam logic [DW-1:0]         DRAIN_LAST = DW'(BUF_LATENCY - 1);

    state_t                r_state;
    logic [IDX_WIDTH-1:0]  r_index;
    logic [PASS_WIDTH-1:0] r_pass;
    logic [DW-1:0]         r_drain;
    logic                  r_busy;
    logic                  r_done;

    logic w_accept;
    logic w_idx_wrap;
    logic w_final;

    assign w_accept   = (r_state == ST_RUN) && !stall;
    assign w_idx_wrap = (r_index == IDX_LAST);
    assign w_final    = w_accept && w_idx_wrap && (r_pass == PASS_LAST);

    // Job FSM: counters advance only on accepted requests, and both
    // counters return to zero once the final request has gone out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_pass  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_index <= '0;
                        r_pass  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_final) begin
                            r_state <= ST_DRAIN;
                            r_index <= '0;
                            r_pass  <= '0;
                            r_drain <= '0;
                        end else if (w_idx_wrap) begin
                            r_index <= '0;
                            r_pass  <= r_pass + 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    valid_delay_line #(
        .DEPTH (BUF_LATENCY)
    ) u_dly (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_accept),
        .i_last  (w_final),
        .o_valid (data_valid),
        .o_last  (last_data)
    );

    assign index       = r_index;
    assign pass_count  = r_pass;
    assign index_valid = w_accept;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_weight_index_sequencer.sv
// Self-checking bench for weight_index_sequencer.
// Directed scenarios followed by random start/stall/reset traffic.
module tb_weight_index_sequencer;

    localparam int N   = 42;
    localparam int P   = 2;
    localparam int L   = 2;
    localparam int TOT = N * P;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic [11:0] index;
    logic        index_valid;
    logic        data_valid;
    logic        last_data;
    logic [6:0]  pass_count;
    logic        busy;
    logic        done;

    weight_index_sequencer #(
        .IDX_WIDTH   (12),
        .NUM_INDICES (N),
        .NUM_PASSES  (P),
        .PASS_WIDTH  (7),
        .BUF_LATENCY (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .index       (index),
        .index_valid (index_valid),
        .data_valid  (data_valid),
        .last_data   (last_data),
        .pass_count  (pass_count),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: job progress as a count of accepted requests,
    // plus the number of cycles elapsed since the last one.
    bit m_run  = 0;
    int m_acc  = 0;
    int m_tail = 0;
    bit h_v [L];
    bit h_l [L];

    int dv_cnt;
    int done_cyc;
    int first_iv;
    int first_dv;
    int last_cyc;

    task automatic chk(input string tag, input int c, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d observed=%0d expected=%0d", tag, c, obs, exp);
        end
    endtask

    task automatic clr_stats();
        dv_cnt   = 0;
        done_cyc = -1;
        first_iv = -1;
        first_dv = -1;
        last_cyc = -1;
    endtask

    // Drive one cycle, compare at the falling edge, advance the model.
    task automatic cyc(input int c, input bit st, input bit sl,
                       input bit rs, input bit en);
        bit e_iv;
        bit e_lr;
        bit idle;
        start = st;
        stall = sl;
        reset = rs;
        @(negedge clk);
        e_iv = m_run && !sl;
        e_lr = e_iv && (m_acc == TOT - 1);
        if (en) begin
            chk("index", c, int'(index), m_acc % N);
            chk("pass_count", c, int'(pass_count), m_acc / N);
            chk("index_valid", c, int'(index_valid), int'(e_iv));
            chk("data_valid", c, int'(data_valid), int'(h_v[L-1]));
            chk("last_data", c, int'(last_data), int'(h_l[L-1]));
            chk("busy", c, int'(busy),
                int'(m_run || (m_tail >= 1 && m_tail <= L)));
            chk("done", c, int'(done), int'(m_tail == L + 1));
        end
        if (data_valid === 1'b1) begin
            dv_cnt++;
            if (first_dv < 0) first_dv = c;
        end
        if (index_valid === 1'b1 && first_iv < 0) first_iv = c;
        if (done === 1'b1 && done_cyc < 0) done_cyc = c;
        if (last_data === 1'b1) last_cyc = c;
        if (rs) begin
            m_run  = 0;
            m_acc  = 0;
            m_tail = 0;
            for (int i = 0; i < L; i++) begin
                h_v[i] = 0;
                h_l[i] = 0;
            end
        end else begin
            for (int i = L - 1; i > 0; i--) begin
                h_v[i] = h_v[i-1];
                h_l[i] = h_l[i-1];
            end
            h_v[0] = e_iv;
            h_l[0] = e_lr;
            idle = !m_run && (m_tail == 0);
            if (m_tail != 0) m_tail = (m_tail == L + 1) ? 0 : m_tail + 1;
            if (e_iv) begin
                m_acc++;
                if (m_acc == TOT) begin
                    m_run  = 0;
                    m_acc  = 0;
                    m_tail = 1;
                end
            end
            if (idle && st) begin
                m_run = 1;
                m_acc = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        start = 0;
        stall = 0;
        reset = 1;
        for (int i = 0; i < L; i++) begin
            h_v[i] = 0;
            h_l[i] = 0;
        end
        @(posedge clk);
        #1;
        cyc(-1, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) cyc(c, 0, 0, 0, 1);

        // Nominal run
        clr_stats();
        for (int c = 0; c < 92; c++) cyc(c, c == 0, 0, 0, 1);
        chk("nom_dv_count", 0, dv_cnt, 84);
        chk("nom_first_iv", 0, first_iv, 1);
        chk("nom_first_dv", 0, first_dv, 3);
        chk("nom_last_data", 0, last_cyc, 86);
        chk("nom_done", 0, done_cyc, 87);

        // Stall for cycles 10..14
        clr_stats();
        for (int c = 0; c < 96; c++)
            cyc(c, c == 0, (c >= 10 && c <= 14), 0, 1);
        chk("stall_dv_count", 0, dv_cnt, 84);
        chk("stall_done", 0, done_cyc, 92);

        // Start while busy, then a genuine restart in IDLE at 88
        clr_stats();
        for (int c = 0; c < 180; c++)
            cyc(c, (c == 0 || c == 20 || c == 86 || c == 88), 0, 0, 1);
        chk("rebusy_done", 0, done_cyc, 87);
        chk("rebusy_dv_count", 0, dv_cnt, 168);

        // Reset mid-job
        clr_stats();
        for (int c = 0; c < 60; c++) cyc(c, c == 0, 0, c == 30, 1);
        chk("rst_dv_count", 0, dv_cnt, 28);
        chk("rst_no_done", 0, done_cyc, -1);

        // Start together with stall
        clr_stats();
        for (int c = 0; c < 96; c++) cyc(c, c == 0, c <= 5, 0, 1);
        chk("ss_first_iv", 0, first_iv, 6);
        chk("ss_first_dv", 0, first_dv, 8);

        // Random traffic
        for (int c = 0; c < 3000; c++)
            cyc(c, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 399) == 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
